addsub_accumulator: RTL and testbench
=====================================

ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 SHALL have parameter n, default 64, meaning operand/accumulator width in bits.
REQ-002 SHALL have parameter cw, default 16, meaning operand-count width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand this cycle.
REQ-007 SHALL have port x_in  input  n  operand, two's complement.
REQ-008 SHALL have port add_n  input  1  0 = add operand, 1 = subtract operand.
REQ-009 SHALL have port last  input  1  operand closes the current packet.
REQ-010 SHALL have port out_valid  output  1  packet result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port acc_out  output  n  accumulated result.
REQ-013 SHALL have port cout_out  output  1  carry-out of the most recent add/sub.
REQ-014 SHALL have port overflow_out  output  1  sticky signed overflow for the packet.
REQ-015 SHALL have port count  output  cw  operands accepted in the current packet.

Function
REQ-016 SHALL implement states IDLE, ACC and DONE, encoded in a registered state variable.
REQ-017 SHALL drive in_ready = 1 in IDLE and ACC and 0 in DONE, decoded from state only, with no dependence on in_valid.
REQ-018 SHALL define accept as in_valid & in_ready.
REQ-019 SHALL compute each step as acc_next = base + (x_in XOR {n{add_n}}) + add_n, where base = 0 in IDLE and acc in ACC, with carry into bit n giving cout_next.
REQ-020 SHALL compute step overflow as (base[n-1] == y'[n-1]) & (acc_next[n-1] != base[n-1]), where y' is the XORed operand.
REQ-021 SHALL, on accept in IDLE, load acc with acc_next, set count to 1 and overflow to the step overflow.
REQ-022 SHALL, on accept in ACC, load acc with acc_next, increment count (saturating at all-ones) and OR the step overflow into the sticky overflow.
REQ-023 SHALL update cout_out on every accept with that step's carry only.
REQ-024 SHALL go to DONE on an accept with last = 1, from either IDLE (single-operand packet) or ACC; otherwise an accept moves IDLE to ACC and ACC stays in ACC.
REQ-025 SHALL hold state, acc, count and flags unchanged in IDLE or ACC on cycles without an accept.
REQ-026 SHALL assert out_valid = 1 only in DONE, with latency of one cycle after the last-accept edge.
REQ-027 SHALL hold acc_out, cout_out, overflow_out and count stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL, in DONE with out_ready = 1, return to IDLE on the next edge and clear acc, count, cout and overflow to 0.
REQ-029 SHALL ignore x_in, add_n and last when in_ready = 0.
REQ-030 SHALL let acc wrap modulo 2^n, with overflow_out the only indication of a signed range violation.
REQ-031 SHALL detect 0 - (most-negative value) as overflow.

Reset
REQ-032 SHALL, when rst = 1 at a rising edge, set state to IDLE and acc, count, cout_out and overflow_out to 0, with out_valid = 0 and in_ready = 1 after that edge.
REQ-033 SHALL give rst priority over accept and over the output handshake in the same cycle.
REQ-034 SHALL, on reset mid-packet (ACC or DONE), discard the partial or pending result without emitting it.

Verification (bench instance n=8, cw=16)
REQ-035 SHALL cover: add 0x05, then add 0x03 with last -> next cycle out_valid=1, acc_out=0x08, cout_out=0, overflow_out=0, count=2.
REQ-036 SHALL cover: add 0x7F, then add 0x01 with last -> acc_out=0x80, overflow_out=1, cout_out=0.
REQ-037 SHALL cover: add 0x05, then subtract 0x07 with last -> acc_out=0xFE, cout_out=0, overflow_out=0; separately, subtract 0x80 alone with last -> acc_out=0x80, overflow_out=1.
REQ-038 SHALL cover: add 0x7F, add 0x01, then subtract 0x01 with last -> acc_out=0x7F, overflow_out=1 (sticky).
REQ-039 SHALL cover: in DONE, hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, count unchanged; then out_ready=1 -> IDLE next cycle with acc_out=0.
REQ-040 SHALL cover: accept two operands, then assert rst for 1 cycle together with in_valid=1 -> IDLE, acc_out=0, count=0, out_valid never asserted.

Source files
------------

// File: rtl/addsub_accumulator.sv
// Packet accumulator: sums or subtracts two's-complement operands until 'last', then
// presents the total with carry, sticky signed overflow and operand count.
module addsub_accumulator #(
  parameter int n  = 64,
  parameter int cw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  x_in,
  input  logic          add_n,
  input  logic          last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  acc_out,
  output logic          cout_out,
  output logic          overflow_out,
  output logic [cw-1:0] count,
  output logic [1:0]    o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // ready never depends on valid, and out_valid holds with its data until out_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [n-1:0]  r_acc;
  logic [cw-1:0] r_count;
  logic          r_cout;
  logic          r_ovf;

  logic          w_accept;
  logic [n-1:0]  w_base;
  logic [n-1:0]  w_y;
  logic [n:0]    w_sum;
  logic          w_step_ovf;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = last ? S_DONE : S_ACC;
      S_ACC:  if (w_accept && last) w_next_state = S_DONE;
      S_DONE: if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_ACC:   in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  // A packet's first operand starts from zero, so the old total never leaks in.
  assign w_base = (r_state == S_ACC) ? r_acc : '0;
  assign w_y    = x_in ^ {n{add_n}};
  assign w_sum  = {1'b0, w_base} + {1'b0, w_y} + {{n{1'b0}}, add_n};
  assign w_step_ovf = (w_base[n-1] == w_y[n-1]) & (w_sum[n-1] != w_base[n-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc  <= w_sum[n-1:0];
      r_cout <= w_sum[n];
      if (r_state == S_IDLE) begin
        r_count <= {{(cw-1){1'b0}}, 1'b1};
        r_ovf   <= w_step_ovf;
      end else begin
        if (r_count != {cw{1'b1}}) r_count <= r_count + 1'b1;
        r_ovf <= r_ovf | w_step_ovf;
      end
    end else if (r_state == S_DONE && out_ready) begin
      r_acc   <= '0;
      r_count <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign acc_out      = r_acc;
  assign cout_out     = r_cout;
  assign overflow_out = r_ovf;
  assign count        = r_count;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator (n=8, cw=16) with hand-computed results.
module tb_addsub_accumulator;

  localparam int N  = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x_in;
  logic          add_n;
  logic          last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  acc_out;
  logic          cout_out;
  logic          overflow_out;
  logic [CW-1:0] count;
  logic [1:0]    dbg_state;

  int n_cmp;
  int n_err;
  logic [N-1:0] exp_q[$];
  logic         watch_ov;
  logic         seen_ov;

  addsub_accumulator #(.n(N), .cw(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x_in         (x_in),
    .add_n        (add_n),
    .last         (last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .acc_out      (acc_out),
    .cout_out     (cout_out),
    .overflow_out (overflow_out),
    .count        (count),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (watch_ov && out_valid) seen_ov = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [N-1:0] x, input logic sub, input logic lst);
    in_valid = 1'b1;
    x_in     = x;
    add_n    = sub;
    last     = lst;
    step();
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic e_cout, input logic e_ovf,
                              input logic [CW-1:0] e_cnt);
    logic [N-1:0] e_acc;
    e_acc = exp_q.pop_front();
    check({tag, ".out_valid"}, out_valid, 1'b1);
    check({tag, ".acc"}, acc_out, e_acc);
    check({tag, ".cout"}, cout_out, e_cout);
    check({tag, ".ovf"}, overflow_out, e_ovf);
    check({tag, ".count"}, count, e_cnt);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, out_valid, 1'b0);
    check({tag, ".idle_acc"}, acc_out, 8'h00);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; x_in = '0; add_n = 1'b0; last = 1'b0; out_ready = 1'b0;
    watch_ov = 1'b0; seen_ov = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst.state", dbg_state, 2'd0);
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.acc", acc_out, 8'h00);
    check("rst.count", count, 16'd0);
    check("rst.flags", {cout_out, overflow_out}, 2'b00);

    // 5 + 3, with idle gap mid-packet that must hold state
    op(8'h05, 1'b0, 1'b0);
    check("add.acc_mid", acc_out, 8'h05);
    step(); step();
    check("add.hold_acc", acc_out, 8'h05);
    check("add.hold_cnt", count, 16'd1);
    check("add.hold_state", dbg_state, 2'd1);
    exp_q.push_back(8'h08);
    op(8'h03, 1'b0, 1'b1);
    check_result("add", 1'b0, 1'b0, 16'd2);

    // stall in DONE with in_valid driven: nothing may change
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x_in = 8'hAA; last = 1'b1;
      step();
      check("stall.in_ready", in_ready, 1'b0);
      check("stall.out_valid", out_valid, 1'b1);
      check("stall.acc", acc_out, 8'h08);
      check("stall.count", count, 16'd2);
    end
    in_valid = 1'b0; last = 1'b0;
    drain("stall");
    check("stall.state", dbg_state, 2'd0);
    check("stall.count0", count, 16'd0);

    // 7F + 01 signed overflow
    op(8'h7F, 1'b0, 1'b0);
    exp_q.push_back(8'h80);
    op(8'h01, 1'b0, 1'b1);
    check_result("ovf", 1'b0, 1'b1, 16'd2);
    drain("ovf");
    check("ovf.cleared", {cout_out, overflow_out}, 2'b00);

    // 5 - 7
    op(8'h05, 1'b0, 1'b0);
    exp_q.push_back(8'hFE);
    op(8'h07, 1'b1, 1'b1);
    check_result("sub", 1'b0, 1'b0, 16'd2);
    drain("sub");

    // 0 - 0x80, single-operand packet
    exp_q.push_back(8'h80);
    op(8'h80, 1'b1, 1'b1);
    check_result("neg_min", 1'b0, 1'b1, 16'd1);
    drain("neg_min");

    // 0 - 0 gives carry 1 from the first step
    exp_q.push_back(8'h00);
    op(8'h00, 1'b1, 1'b1);
    check_result("sub_zero", 1'b1, 1'b0, 16'd1);
    drain("sub_zero");

    // sticky overflow: 7F + 01 - 01 = 7F (0x80 + 0xFE + 1 carries out)
    op(8'h7F, 1'b0, 1'b0);
    op(8'h01, 1'b0, 1'b0);
    exp_q.push_back(8'h7F);
    op(8'h01, 1'b1, 1'b1);
    check_result("sticky", 1'b1, 1'b1, 16'd3);
    drain("sticky");

    // reset mid-packet with in_valid high
    watch_ov = 1'b1;
    op(8'h11, 1'b0, 1'b0);
    op(8'h22, 1'b0, 1'b0);
    check("mid.acc_before", acc_out, 8'h33);
    rst = 1'b1; in_valid = 1'b1; x_in = 8'h44; last = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; last = 1'b0;
    check("mid.state", dbg_state, 2'd0);
    check("mid.acc", acc_out, 8'h00);
    check("mid.count", count, 16'd0);
    check("mid.in_ready", in_ready, 1'b1);
    step(); step(); step();
    check("mid.no_valid", seen_ov, 1'b0);
    watch_ov = 1'b0;

    check("queue.empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
